// File: rtl/xoodyak_result_collector.sv
// Captures crypt/decrypt/squeeze results from xoodyak_build and streams them as 32-bit words.
// Latency: a capture at edge N shows its first word in cycle N+1; no same-cycle bypass.
// Backpressure: dout_ready low holds the current word stable; captures that arrive while full are dropped and flagged.
//
// Ports:
//   eph1, reset                  clock and synchronous active-high reset
//   finished, opmode, textout    completion pulse, op code and result block from the core
//   verify_en, exp_tag           enable and reference value for the squeeze tag compare
//   dout, dout_valid, dout_ready word stream handshake
//   dout_last, dout_kind         end-of-block marker and block type (0 crypt, 1 decrypt, 2 tag)
//   tag_ok, tag_fail             one-cycle compare result pulses
//   overflow                     sticky dropped-capture flag
//   fifo_count                   occupied block entries, 0..DEPTH
module xoodyak_result_collector #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                     eph1,
    input  logic                     reset,
    input  logic                     finished,
    input  logic [3:0]               opmode,
    input  logic [191:0]             textout,
    input  logic                     verify_en,
    input  logic [127:0]             exp_tag,
    output logic [WORD_W-1:0]        dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic [1:0]               dout_kind,
    output logic                     tag_ok,
    output logic                     tag_fail,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [191:0]  r_data [DEPTH];
    logic [1:0]    r_kind [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_word;
    logic          r_tag_ok;
    logic          r_tag_fail;
    logic          r_overflow;

    logic [2:0]    w_op;
    logic          w_capture;
    logic          w_full;
    logic          w_push;
    logic          w_valid;
    logic [191:0]  w_head_data;
    logic [1:0]    w_head_kind;
    logic [2:0]    w_last_idx;
    logic [2:0]    w_slot;
    logic [31:0]   w_word;
    logic          w_xfer;
    logic          w_pop;
    logic          w_tag_match;
    logic          w_unused;

    assign w_unused  = opmode[3];
    assign w_op      = opmode[2:0];
    assign w_capture = finished && ((w_op == 3'd4) || (w_op == 3'd5) || (w_op == 3'd6));
    // Fullness is judged on the registered count, so a pop in the same cycle does not make room.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = w_capture && !w_full;

    assign w_valid     = (r_count != '0);
    assign w_head_data = r_data[r_rd_ptr];
    assign w_head_kind = r_kind[r_rd_ptr];
    assign w_last_idx  = (w_head_kind == 2'd2) ? 3'd3 : 3'd5;
    // Tags live in the low 128 bits, so their word 0 sits at the third 32-bit slot from the top.
    assign w_slot      = (w_head_kind == 2'd2) ? (r_word + 3'd2) : r_word;
    assign w_xfer      = w_valid && dout_ready;
    assign w_pop       = w_xfer && (r_word == w_last_idx);
    assign w_tag_match = (textout[127:0] == exp_tag);

    always_comb begin
        w_word = '0;
        case (w_slot)
            3'd0:    w_word = w_head_data[191:160];
            3'd1:    w_word = w_head_data[159:128];
            3'd2:    w_word = w_head_data[127:96];
            3'd3:    w_word = w_head_data[95:64];
            3'd4:    w_word = w_head_data[63:32];
            3'd5:    w_word = w_head_data[31:0];
            default: w_word = '0;
        endcase
    end

    // Storage needs no reset: entries are only read while the count says they are occupied.
    always_ff @(posedge eph1) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= (w_op == 3'd6) ? {64'd0, textout[127:0]} : textout;
            // Ops 4/5/6 map directly onto kinds 0/1/2 through their low two bits.
            r_kind[r_wr_ptr] <= w_op[1:0];
        end
    end

    always_ff @(posedge eph1) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_tag_ok   <= 1'b0;
            r_tag_fail <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_capture && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_xfer) begin
                r_word <= w_pop ? 3'd0 : (r_word + 3'd1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The compare runs even when the block itself is dropped on overflow.
            r_tag_ok   <= w_capture && (w_op == 3'd6) && verify_en && w_tag_match;
            r_tag_fail <= w_capture && (w_op == 3'd6) && verify_en && !w_tag_match;
        end
    end

    assign dout       = w_valid ? WORD_W'(w_word) : '0;
    assign dout_valid = w_valid;
    assign dout_last  = w_valid && (r_word == w_last_idx);
    assign dout_kind  = w_valid ? w_head_kind : 2'd0;
    assign tag_ok     = r_tag_ok;
    assign tag_fail   = r_tag_fail;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

endmodule

// File: doc/xoodyak_result_collector.md
Name: xoodyak_result_collector

Overview:
- Sits on the output side of xoodyak_build, the opposite end from the command/opmode driver.
- Captures each completed crypt, decrypt or squeeze result when the core pulses finished, buffers whole blocks in a small FIFO, and streams them out as 32-bit words over a valid/ready interface.
- On squeeze results, compares the 128-bit tag against an expected tag and reports pass or fail.

Parameters:
- DEPTH, 4, number of 192-bit result blocks buffered; power of two, minimum 2.
- WORD_W, 32, output word width; fixed at 32, other values unsupported.

Ports:
- eph1  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- finished  input  1  one-cycle pulse from core: operation complete, textout valid this cycle.
- opmode  input  4  opmode of the completing operation; bit 3 (continue) ignored; low 3 bits select the op.
- textout  input  192  core result block.
- verify_en  input  1  enables tag compare on squeeze capture.
- exp_tag  input  128  expected tag; sampled in the capture cycle.
- dout  output  32  output word.
- dout_valid  output  1  dout holds a valid word.
- dout_ready  input  1  downstream accepts the word when high together with dout_valid.
- dout_last  output  1  marks the final word of a block.
- dout_kind  output  2  block type: 0 crypt, 1 decrypt, 2 tag.
- tag_ok  output  1  one-cycle pulse: compare matched.
- tag_fail  output  1  one-cycle pulse: compare mismatched.
- overflow  output  1  sticky flag: a capture was dropped.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; FIFO empty; word counter 0; overflow cleared. Reset mid-stream discards all buffered and in-flight data. No handshake completes in the reset cycle.
- Capture happens when finished=1 and opmode[2:0] is 4, 5 or 6:
  - op 4 pushes {kind 0, textout}.
  - op 5 pushes {kind 1, textout}.
  - op 6 pushes {kind 2, textout[127:0]}.
  - Ops 0–3 and 7 are ignored; finished=0 is ignored regardless of opmode.
- Full FIFO: fullness is evaluated before any same-cycle pop. A capture while full is dropped, overflow is set and held until reset, and FIFO contents are unchanged.
- Latency: a capture at edge N into an empty FIFO gives dout_valid=1 after edge N, i.e. first word visible in cycle N+1.
- Serialization is MSB first:
  - Kind 0/1: 6 words, word 0 = textout[191:160] … word 5 = textout[31:0].
  - Kind 2: 4 words, word 0 = tag[127:96] … word 3 = tag[31:0].
  - dout_last=1 only on word 5 (kind 0/1) or word 3 (kind 2).
- Handshake:
  - A transfer occurs when dout_valid and dout_ready are both high.
  - While dout_valid=1 and dout_ready=0, dout, dout_last and dout_kind hold stable.
  - dout_valid never drops without a transfer, except on reset.
  - The word counter advances on each transfer. On the last-word transfer the head entry pops, the counter returns to 0, and the next entry (if any) is presented in the following cycle with no bubble.
- Simultaneous push and pop (not full): both take effect and fifo_count is unchanged. A push into an empty FIFO is not bypassed to dout in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Tag compare:
  - On op-6 capture with verify_en=1, compare textout[127:0] against exp_tag.
  - One cycle later, pulse tag_ok on a match or tag_fail on a mismatch; never both.
  - With verify_en=0, neither pulses.
  - The compare happens even if the push is dropped on overflow.
- Input conditions not defined: X on textout while finished=0 is don't-care.

Test Plan:
- Single crypt: finished=1, opmode=4, textout=192'h4d4e4f5051525354555657584142434445464748494a4b4c, dout_ready=1 → dout_valid from the next cycle; words 4d4e4f50, 51525354, 55565758, 41424344, 45464748, 494a4b4c; dout_last on the 6th word; dout_kind=0.
- Squeeze with verify: opmode=6, textout[127:0]=exp_tag=128'h38393a3b3c3d3e3f3031323334353637, verify_en=1 → tag_ok pulses for exactly 1 cycle and tag_fail stays 0; 4 words 38393a3b … 34353637 with kind 2 and last on the 4th. Repeat with exp_tag bit 0 flipped → tag_fail pulses, tag_ok stays 0.
- Backpressure: dout_ready=0 for 5 cycles mid-block → dout held constant; after releasing ready, the remaining words arrive in order with no duplicates or losses.
- Overflow: with dout_ready=0, capture DEPTH+1 crypt blocks → fifo_count=4 and overflow=1; draining yields the first 4 blocks only.
- Ignored ops and wrap: finished with opmodes 0,1,2,3,7 → no push. Then 10 back-to-back crypt/decrypt captures under continuous ready → all 60 words in capture order with correct kinds, and pointers wrap cleanly.
- Reset mid-block: assert reset after word 2 of a block → next cycle all outputs 0, fifo_count=0, overflow=0; a fresh capture streams from word 0.
